iram_arb: RTL and testbench

Arbiter and sequencer for the single-port instruction RAM. Shares one RAM port between two requesters:
- the fetch unit (read-only);
- the program loader/debug port (read and write).

It issues one RAM command per cycle, tracks the 1-cycle registered read latency, and routes each read response back to the requester that issued it. A stall counter bounds how long the loader can starve fetch.

---
 rtl/iram_arb.sv | 173 +++++++++++++++++
 tb/tb_iram_arb.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/iram_arb.sv
// -----------------------------------------------------------------------------
// iram_arb -- arbiter/sequencer for the single-port instruction RAM.
//
// Shares one RAM port between the fetch unit (read-only) and the program
// loader/debug port (read/write). One command per cycle, combinational grant,
// 1-cycle registered read latency with per-read owner tracking so each
// response is routed back to whoever issued it.
//
// Build option:
//   IRAM_ARB_RR_EN  defined   -> round-robin between the two requesters
//                   undefined -> loader has fixed priority, bounded by a
//                                MAX_STALL anti-starvation counter
//
// Parameters:
//   IRAM_AW    RAM word-address width (depth 2^IRAM_AW x 32-bit)
//   MAX_STALL  max consecutive loader grants while fetch waits (>= 1)
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   f_req/f_addr               fetch read request
//   f_gnt                      fetch accepted this cycle
//   f_rvalid/f_rdata           fetch read response (1-cycle pulse)
//   l_req/l_we/l_addr/l_wdata  loader request (write when l_we=1)
//   l_gnt                      loader accepted this cycle
//   l_rvalid/l_rdata           loader read response (reads only)
//   ram_en/ram_we/ram_addr/ram_wdata  RAM command
//   ram_rdata                  RAM registered read data
// -----------------------------------------------------------------------------
module iram_arb #(
  parameter int IRAM_AW   = 10,
  parameter int MAX_STALL = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               f_req,
  input  logic [IRAM_AW-1:0] f_addr,
  output logic               f_gnt,
  output logic               f_rvalid,
  output logic [31:0]        f_rdata,
  input  logic               l_req,
  input  logic               l_we,
  input  logic [IRAM_AW-1:0] l_addr,
  input  logic [31:0]        l_wdata,
  output logic               l_gnt,
  output logic               l_rvalid,
  output logic [31:0]        l_rdata,
  output logic               ram_en,
  output logic               ram_we,
  output logic [IRAM_AW-1:0] ram_addr,
  output logic [31:0]        ram_wdata,
  input  logic [31:0]        ram_rdata
);

  logic w_f_gnt;
  logic w_l_gnt;
  logic w_fetch_wins;   // tie-break result when both request
  logic w_resp_ok;
  logic r_pend;         // a read was issued last cycle
  logic r_owner_l;      // 1 = that read belongs to the loader

`ifdef IRAM_ARB_RR_EN
  // r_last_f = 1 means fetch won the last grant, so the loader goes next.
  // Reset value 1 makes the loader the first winner after reset.
  logic r_last_f;

  // Round-robin tie-break: the requester that did not win last time wins.
  always_comb begin
    w_fetch_wins = ~r_last_f;
  end

  // Round-robin pointer: records the winner of every grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_f <= 1'b1;
    end else if (w_f_gnt || w_l_gnt) begin
      r_last_f <= w_f_gnt;
    end else begin
      r_last_f <= r_last_f;
    end
  end
`else
  localparam int                 CW        = $clog2(MAX_STALL + 1);
  localparam logic [CW-1:0]      STALL_MAX = CW'(MAX_STALL);

  logic [CW-1:0] r_stall;

  // Fixed-priority tie-break: loader wins until fetch has waited MAX_STALL
  // loader grants in a row.
  always_comb begin
    w_fetch_wins = (r_stall == STALL_MAX);
  end

  // Stall counter: counts loader grants taken while fetch was waiting,
  // saturating at MAX_STALL; any fetch grant or fetch idle clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall <= {CW{1'b0}};
    end else if (!f_req || w_f_gnt) begin
      r_stall <= {CW{1'b0}};
    end else if (w_l_gnt && (r_stall != STALL_MAX)) begin
      r_stall <= r_stall + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      r_stall <= r_stall;
    end
  end
`endif

  // Grant decision: at most one grant, never without a request, none in reset.
  always_comb begin
    w_f_gnt = 1'b0;
    w_l_gnt = 1'b0;
    if (!rst_n) begin
      w_f_gnt = 1'b0;
      w_l_gnt = 1'b0;
    end else if (f_req && l_req) begin
      w_f_gnt = w_fetch_wins;
      w_l_gnt = ~w_fetch_wins;
    end else begin
      w_f_gnt = f_req;
      w_l_gnt = l_req;
    end
  end

  // RAM command mux driven straight from the winner.
  always_comb begin
    f_gnt     = w_f_gnt;
    l_gnt     = w_l_gnt;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = {IRAM_AW{1'b0}};
    ram_wdata = 32'h0000_0000;
    if (w_f_gnt) begin
      ram_en   = 1'b1;
      ram_addr = f_addr;
    end else if (w_l_gnt) begin
      ram_en    = 1'b1;
      ram_we    = l_we;
      ram_addr  = l_addr;
      ram_wdata = l_wdata;
    end else begin
      ram_en = 1'b0;
    end
  end

  // Read tracking: a read granted this cycle returns data next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend    <= 1'b0;
      r_owner_l <= 1'b0;
    end else begin
      r_pend    <= w_f_gnt | (w_l_gnt & ~l_we);
      r_owner_l <= w_l_gnt;
    end
  end

  // Response routing. Gating with rst_n drops a read whose response cycle
  // coincides with reset being asserted.
  always_comb begin
    w_resp_ok = rst_n & r_pend;
    f_rvalid  = w_resp_ok & ~r_owner_l;
    l_rvalid  = w_resp_ok & r_owner_l;
    f_rdata   = 32'h0000_0000;
    l_rdata   = 32'h0000_0000;
    if (f_rvalid) begin
      f_rdata = ram_rdata;
    end else if (l_rvalid) begin
      l_rdata = ram_rdata;
    end else begin
      f_rdata = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_iram_arb.sv
// -----------------------------------------------------------------------------
// tb_iram_arb -- self-checking bench for iram_arb.
// A table of directed vectors, hand-built contention sequences and a random
// phase, all checked against a behavioural model of the arbitration rules and
// a reference copy of the RAM contents.
// -----------------------------------------------------------------------------
module tb_iram_arb;

  localparam int AW = 10;
  localparam int MS = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_gnt;
  logic          f_rvalid;
  logic [31:0]   f_rdata;
  logic          l_req;
  logic          l_we;
  logic [AW-1:0] l_addr;
  logic [31:0]   l_wdata;
  logic          l_gnt;
  logic          l_rvalid;
  logic [31:0]   l_rdata;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata = 32'h0;

  always #5 clk = ~clk;

  iram_arb #(.IRAM_AW(AW), .MAX_STALL(MS)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Single-port RAM with registered read
  logic [31:0] ram     [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram[ram_addr];
    end
  end

  typedef struct {
    logic          rst_n;
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          l_req;
    logic          l_we;
    logic [AW-1:0] l_addr;
    logic [31:0]   l_wdata;
    logic          chk;
    logic          ef_gnt;
    logic          el_gnt;
    logic          ef_rv;
    logic          el_rv;
    logic [31:0]   e_rdata;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  int          m_stall  = 0;
  bit          m_last_f = 1'b1;
  bit          m_pend   = 1'b0;
  bit          m_pend_l = 1'b0;
  logic [31:0] m_pend_data = 32'h0;

  function automatic vec_t mk(input logic rs, input logic fr, input logic [AW-1:0] fa,
                              input logic lr, input logic lw, input logic [AW-1:0] la,
                              input logic [31:0] wd, input logic ck,
                              input logic efg, input logic elg, input logic efr,
                              input logic elr, input logic [31:0] erd);
    vec_t v;
    v.rst_n = rs; v.f_req = fr; v.f_addr = fa; v.l_req = lr; v.l_we = lw;
    v.l_addr = la; v.l_wdata = wd; v.chk = ck; v.ef_gnt = efg; v.el_gnt = elg;
    v.ef_rv = efr; v.el_rv = elr; v.e_rdata = erd;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    logic        ef, el, efr, elr, en, we;
    logic [AW-1:0] ea;
    logic [31:0]   ewd;
    #1;
    rst_n = v.rst_n; f_req = v.f_req; f_addr = v.f_addr;
    l_req = v.l_req; l_we = v.l_we; l_addr = v.l_addr; l_wdata = v.l_wdata;
    @(negedge clk);
    ef = 1'b0; el = 1'b0;
    if (v.rst_n) begin
      if (v.f_req && v.l_req) begin
`ifdef IRAM_ARB_RR_EN
        ef = !m_last_f;
`else
        ef = (m_stall >= MS);
`endif
        el = !ef;
      end else begin
        ef = v.f_req;
        el = v.l_req;
      end
    end
    en  = ef | el;
    we  = el & v.l_we;
    ea  = ef ? v.f_addr : (el ? v.l_addr : '0);
    ewd = el ? v.l_wdata : 32'h0;
    efr = v.rst_n && m_pend && !m_pend_l;
    elr = v.rst_n && m_pend && m_pend_l;
    cmp("grant", {f_gnt, l_gnt}, {ef, el});
    cmp("ram_cmd", {ram_en, ram_we, ram_addr, ram_wdata}, {en, we, ea, ewd});
    cmp("resp", {f_rvalid, l_rvalid, f_rdata, l_rdata},
        {efr, elr, (efr ? m_pend_data : 32'h0), (elr ? m_pend_data : 32'h0)});
    if (v.chk) begin
      cmp("tbl_grant", {f_gnt, l_gnt}, {v.ef_gnt, v.el_gnt});
      cmp("tbl_resp", {f_rvalid, l_rvalid, f_rdata, l_rdata},
          {v.ef_rv, v.el_rv, (v.ef_rv ? v.e_rdata : 32'h0), (v.el_rv ? v.e_rdata : 32'h0)});
    end
    @(posedge clk);
    if (!v.rst_n) begin
      m_stall = 0; m_last_f = 1'b1; m_pend = 1'b0; m_pend_l = 1'b0;
    end else begin
      m_pend   = ef | (el & !v.l_we);
      m_pend_l = el;
      if (ef) m_pend_data = ref_mem[v.f_addr];
      else if (el && !v.l_we) m_pend_data = ref_mem[v.l_addr];
      if (el && v.l_we) ref_mem[v.l_addr] = v.l_wdata;
      if (ef || el) m_last_f = ef;
      if (!v.f_req || ef) m_stall = 0;
      else if (el && m_stall < MS) m_stall = m_stall + 1;
    end
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
    bit   pf, pl;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]     = 32'h5A00_0000 ^ i;
      ref_mem[i] = 32'h5A00_0000 ^ i;
    end
    ram[16]     = 32'h0010_0093;
    ref_mem[16] = 32'h0010_0093;
    rst_n = 1'b0; f_req = 1'b0; f_addr = '0; l_req = 1'b0; l_we = 1'b0;
    l_addr = '0; l_wdata = 32'h0;

    // rst, freq, faddr, lreq, lwe, laddr, wdata, chk, fgnt, lgnt, frv, lrv, rdata
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1'b0, 1'b1, 10'h10, 1'b1, 1'b0, 10'h5, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, 1'b1, 10'h10, 1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, 1'b0, 10'h0,  1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0010_0093));
    tbl.push_back(mk(1'b1, 1'b0, 10'h0,  1'b1, 1'b1, 10'h5, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, 1'b1, 10'h5,  1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, 1'b0, 10'h0,  1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF));
    tbl.push_back(mk(1'b1, 1'b0, 10'h0,  1'b1, 1'b0, 10'h5, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, 1'b1, 10'h10, 1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF));
    tbl.push_back(mk(1'b1, 1'b0, 10'h0,  1'b1, 1'b0, 10'h10, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0010_0093));
    tbl.push_back(mk(1'b1, 1'b0, 10'h0,  1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0010_0093));
    // reset while a fetch read is in flight: the response is dropped
    tbl.push_back(mk(1'b1, 1'b1, 10'h10, 1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk(1'b0, 1'b0, 10'h0,  1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, 1'b0, 10'h0,  1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, 1'b1, 10'h5,  1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, 1'b0, 10'h0,  1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF));
    tbl.push_back(mk(1'b1, 1'b0, 10'h0,  1'b1, 1'b1, 10'h10, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, 1'b0, 10'h0,  1'b1, 1'b0, 10'h10, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, 1'b0, 10'h0,  1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678));

    foreach (tbl[i]) step(tbl[i]);

    // Contention from a fresh reset: fetch reads 0x10, loader reads 5
    step(mk(1'b0, 1'b0, 10'h0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
    pf = 1'b0; pl = 1'b0;
`ifdef IRAM_ARB_RR_EN
    for (int i = 0; i < 6; i++) begin
      v = mk(1'b1, 1'b1, 10'h10, 1'b1, 1'b0, 10'h5, 32'h0, 1'b1,
             (i % 2) == 1, (i % 2) == 0, pf, pl, pf ? 32'h1234_5678 : 32'hDEAD_BEEF);
      step(v);
      pf = v.ef_gnt; pl = v.el_gnt;
    end
`else
    for (int i = 0; i < 15; i++) begin
      v = mk(1'b1, 1'b1, 10'h10, 1'b1, 1'b0, 10'h5, 32'h0, 1'b1,
             (i % 5) == 4, (i % 5) != 4, pf, pl, pf ? 32'h1234_5678 : 32'hDEAD_BEEF);
      step(v);
      pf = v.ef_gnt; pl = v.el_gnt;
    end
`endif

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      v = mk($urandom_range(0, 39) != 0, $urandom_range(0, 2) != 0, AW'($urandom_range(0, 7)),
             $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)),
             $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      if ($urandom_range(0, 9) == 0) v.f_addr = AW'($urandom);
      step(v);
    end
    step(mk(1'b1, 1'b0, 10'h0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
